// File: rtl/serial_bus_loader.sv
// Host command parser that drives the 6502 bus while the CPU is held in reset.
// Optional BUS_LOADER_CKSUM_EN adds a mod-256 data checksum to W/R replies.
module serial_bus_loader #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [7:0]        bus_dout,
    input  logic [7:0]        bus_din,
    output logic              cpu_run
);

    // state  | meaning
    // IDLE   | waiting for a command byte
    // ADDR_H | waiting for address high byte
    // ADDR_L | waiting for address low byte
    // LEN    | waiting for length byte (0 = 256)
    // WDATA  | receiving write data, one bus write per byte
    // RBUS   | read address on bus
    // RWAIT  | registered memory returns data, capture it
    // TXB    | send captured byte once uart is free
    // REPLY  | send status/checksum byte once uart is free
    typedef enum logic [3:0] {
        IDLE, ADDR_H, ADDR_L, LEN, WDATA, RBUS, RWAIT, TXB, REPLY
    } state_t;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] RSP_OK   = 8'h2B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;
    localparam logic [7:0] RSP_BUSY = 8'h21;

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [8:0]        cnt;
    logic [7:0]        addr_h;
    logic [7:0]        rd_byte;
    logic [7:0]        reply_byte;
    logic              is_write;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_done;
    logic              tx_go;
    logic              wr_go;
`ifdef BUS_LOADER_CKSUM_EN
    logic [7:0]        sum;
`endif

    assign tmo_done = (tmo_cnt == '0) && !rx_valid;
    assign tx_go    = !tx_busy && !tx_start;
    // back-to-back strobes cannot come from the uart; guard keeps bus_we single-cycle
    assign wr_go    = rx_valid && !bus_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (rx_valid)
                        state_nxt = ((rx_data == CMD_W || rx_data == CMD_R) && !cpu_run) ? ADDR_H : REPLY;
            ADDR_H: if (rx_valid) state_nxt = ADDR_L; else if (tmo_done) state_nxt = IDLE;
            ADDR_L: if (rx_valid) state_nxt = LEN;    else if (tmo_done) state_nxt = IDLE;
            LEN:    if (rx_valid) state_nxt = is_write ? WDATA : RBUS;
                    else if (tmo_done) state_nxt = IDLE;
            WDATA:  if (wr_go && cnt == 9'd1) state_nxt = REPLY;
                    else if (tmo_done) state_nxt = IDLE;
            RBUS:   state_nxt = RWAIT;
            RWAIT:  state_nxt = TXB;
            TXB:    if (tx_go) begin
                        if (cnt != 9'd1) state_nxt = RBUS;
`ifdef BUS_LOADER_CKSUM_EN
                        else             state_nxt = REPLY;
`else
                        else             state_nxt = IDLE;
`endif
                    end
            REPLY:  if (tx_go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data    <= '0;
            tx_start   <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= 1'b0;
            bus_dout   <= '0;
            cpu_run    <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            addr_h     <= '0;
            rd_byte    <= '0;
            reply_byte <= '0;
            is_write   <= 1'b0;
            tmo_cnt    <= TMO_LOAD;
`ifdef BUS_LOADER_CKSUM_EN
            sum        <= '0;
`endif
        end else begin
            bus_we   <= 1'b0;
            tx_start <= 1'b0;
            if (rx_valid || state == IDLE) tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)        tmo_cnt <= tmo_cnt - 1'b1;
            case (state)
                IDLE: if (rx_valid) begin
                    is_write <= (rx_data == CMD_W);
`ifdef BUS_LOADER_CKSUM_EN
                    sum      <= '0;
`endif
                    case (rx_data)
                        CMD_W, CMD_R: reply_byte <= RSP_BUSY;
                        CMD_G: begin cpu_run <= 1'b1; reply_byte <= RSP_OK; end
                        CMD_H: begin cpu_run <= 1'b0; reply_byte <= RSP_OK; end
                        default: reply_byte <= RSP_BAD;
                    endcase
                end
                ADDR_H: if (rx_valid) addr_h <= rx_data;
                ADDR_L: if (rx_valid) ptr <= ADDR_W'({addr_h, rx_data});
                LEN: if (rx_valid) begin
                    cnt        <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    reply_byte <= RSP_OK;
                    if (!is_write) bus_addr <= ptr;
                end
                WDATA: if (wr_go) begin
                    bus_we   <= 1'b1;
                    bus_addr <= ptr;
                    bus_dout <= rx_data;
                    ptr      <= ptr + 1'b1;
                    cnt      <= cnt - 9'd1;
`ifdef BUS_LOADER_CKSUM_EN
                    sum        <= sum + rx_data;
                    reply_byte <= sum + rx_data;
`endif
                end
                RWAIT: rd_byte <= bus_din;
                TXB: if (tx_go) begin
                    tx_start <= 1'b1;
                    tx_data  <= rd_byte;
                    ptr      <= ptr + 1'b1;
                    cnt      <= cnt - 9'd1;
                    if (cnt != 9'd1) bus_addr <= ptr + 1'b1;
`ifdef BUS_LOADER_CKSUM_EN
                    sum        <= sum + rd_byte;
                    reply_byte <= sum + rd_byte;
`endif
                end
                REPLY: if (tx_go) begin
                    tx_start <= 1'b1;
                    tx_data  <= reply_byte;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_loader.sv
// Directed bench for serial_bus_loader: registered RAM model, uart TX model, host byte driver.
module tb_serial_bus_loader;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [15:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        cpu_run;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  tx_q [$];
    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int          busy_cnt = 0;
    int          start_viol = 0;
    int          we_viol = 0;
    logic        we_prev = 1'b0;

    serial_bus_loader #(.TIMEOUT_CYC(TMO), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_dout(bus_dout),
        .bus_din(bus_din), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_we) begin
            mem[bus_addr] <= bus_dout;
            wa_q.push_back(bus_addr);
            wd_q.push_back(bus_dout);
        end
        bus_din <= mem[bus_addr];
        if (bus_we && we_prev) we_viol++;
        we_prev <= bus_we;
    end

    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_start) begin
            if (tx_busy) start_viol++;
            tx_q.push_back(tx_data);
            busy_cnt <= 4;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx(input int n);
        int c;
        c = 0;
        while (tx_q.size() < n && c < 6000) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_data"},  tx_data,  8'h00);
        chk({tag, "_tx_start"}, tx_start, 1'b0);
        chk({tag, "_bus_addr"}, bus_addr, 16'h0000);
        chk({tag, "_bus_we"},   bus_we,   1'b0);
        chk({tag, "_bus_dout"}, bus_dout, 8'h00);
        chk({tag, "_cpu_run"},  cpu_run,  1'b0);
    endtask

    initial begin
        int base;
        int wbase;
        int errs;
        logic [7:0] exp_b;
        logic [7:0] csum;
        logic [15:0] addr_hold;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // write three bytes
        base = tx_q.size();
        send(8'h57); send(8'h02); send(8'h00); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        wait_tx(base + 1);
        chk("w1_reply_cnt", tx_q.size(), base + 1);
`ifdef BUS_LOADER_CKSUM_EN
        chk("w1_reply", tx_q[base], 8'h31);
`else
        chk("w1_reply", tx_q[base], 8'h2B);
`endif
        chk("w1_nwr", wa_q.size(), 3);
        chk("w1_a0", wa_q[0], 16'h0200); chk("w1_d0", wd_q[0], 8'hAA);
        chk("w1_a1", wa_q[1], 16'h0201); chk("w1_d1", wd_q[1], 8'hBB);
        chk("w1_a2", wa_q[2], 16'h0202); chk("w1_d2", wd_q[2], 8'hCC);

        // read them back
        base = tx_q.size(); wbase = wa_q.size();
        send(8'h52); send(8'h02); send(8'h00); send(8'h03);
`ifdef BUS_LOADER_CKSUM_EN
        wait_tx(base + 4);
        chk("r1_cnt", tx_q.size(), base + 4);
        chk("r1_cksum", tx_q[base+3], 8'h31);
`else
        wait_tx(base + 3);
        repeat (20) @(negedge clk);
        chk("r1_cnt", tx_q.size(), base + 3);
`endif
        chk("r1_b0", tx_q[base],   8'hAA);
        chk("r1_b1", tx_q[base+1], 8'hBB);
        chk("r1_b2", tx_q[base+2], 8'hCC);
        chk("r1_no_we", wa_q.size(), wbase);

        // write across the address wrap
        base = tx_q.size(); wbase = wa_q.size();
        send(8'h57); send(8'hFF); send(8'hFF); send(8'h02); send(8'h11); send(8'h22);
        wait_tx(base + 1);
`ifdef BUS_LOADER_CKSUM_EN
        chk("w3_reply", tx_q[base], 8'h33);
`else
        chk("w3_reply", tx_q[base], 8'h2B);
`endif
        chk("w3_a0", wa_q[wbase],   16'hFFFF); chk("w3_d0", wd_q[wbase],   8'h11);
        chk("w3_a1", wa_q[wbase+1], 16'h0000); chk("w3_d1", wd_q[wbase+1], 8'h22);

        // read across the wrap
        base = tx_q.size();
        send(8'h52); send(8'hFF); send(8'hFF); send(8'h02);
        wait_tx(base + 2);
        chk("rw_b0", tx_q[base],   8'h11);
        chk("rw_b1", tx_q[base+1], 8'h22);

        // len=0 reads exactly 256 bytes from 0xFF00
        repeat (20) @(negedge clk);
        base = tx_q.size();
        send(8'h52); send(8'hFF); send(8'h00); send(8'h00);
`ifdef BUS_LOADER_CKSUM_EN
        wait_tx(base + 257);
        repeat (40) @(negedge clk);
        chk("r256_cnt", tx_q.size(), base + 257);
`else
        wait_tx(base + 256);
        repeat (40) @(negedge clk);
        chk("r256_cnt", tx_q.size(), base + 256);
`endif
        errs = 0;
        csum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            exp_b = (i == 255) ? 8'h11 : (8'(i) ^ 8'h5A);
            csum  = csum + exp_b;
            if (base + i >= tx_q.size() || tx_q[base+i] !== exp_b) errs++;
        end
        chk("r256_data_errs", errs, 0);
`ifdef BUS_LOADER_CKSUM_EN
        chk("r256_cksum", tx_q[base+256], csum);
`endif

        // run/halt and busy refusal
        base = tx_q.size();
        send(8'h47);
        wait_tx(base + 1);
        chk("g_reply", tx_q[base], 8'h2B);
        chk("g_cpu_run", cpu_run, 1'b1);
        wbase = wa_q.size(); addr_hold = bus_addr;
        send(8'h52);
        wait_tx(base + 2);
        chk("busy_reply", tx_q[base+1], 8'h21);
        chk("busy_no_we", wa_q.size(), wbase);
        chk("busy_addr_hold", bus_addr, addr_hold);
        send(8'h48);
        wait_tx(base + 3);
        chk("h_reply", tx_q[base+2], 8'h2B);
        chk("h_cpu_run", cpu_run, 1'b0);

        // timeout mid-command, then an unknown byte
        base = tx_q.size();
        send(8'h57); send(8'h03);
        repeat (TMO + 10) @(negedge clk);
        chk("tmo_no_tx", tx_q.size(), base);
        send(8'h5A);
        wait_tx(base + 1);
        chk("tmo_bad_reply", tx_q[base], 8'h3F);

        // asynchronous reset mid-write
        base = tx_q.size(); wbase = wa_q.size();
        send(8'h57); send(8'h04); send(8'h00); send(8'h04); send(8'h77);
        chk("mid_addr_before", bus_addr, 16'h0400);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_tx", tx_q.size(), base);
        chk("midrst_one_wr", wa_q.size(), wbase + 1);
        send(8'h52); send(8'h04); send(8'h00); send(8'h01);
        wait_tx(base + 1);
        chk("midrst_readback", tx_q[base], 8'h77);

        repeat (20) @(negedge clk);
        chk("we_never_2cyc", we_viol, 0);
        chk("start_only_idle", start_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
